// File: rtl/mdio_responder.sv
// MDIO (clause 22) PHY-side responder: oversamples MDC/MDIO on clk, decodes
// read/write frames addressed to PHY_ADDR and drives read data back.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int         PRE_LEN  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr,
  output logic        reg_rd_req,
  input  logic [15:0] reg_rd_data,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_data,
  output logic        frame_err
);
  localparam int PW = $clog2(PRE_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_RDATA, S_WDATA
  } state_t;

  logic          mdc_s1_q, mdc_s2_q, mdc_s3_q;
  logic          mdio_s1_q, mdio_s2_q;
  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          is_rd_q, is_rd_d;
  logic          drain_q, drain_d;
  logic [3:0]    fld_q, fld_d;
  logic [4:0]    reg_addr_q, reg_addr_d;
  logic [15:0]   data_sh_q, data_sh_d;
  logic [15:0]   reg_wr_data_q, reg_wr_data_d;
  logic          mdio_o_q, mdio_o_d;
  logic          mdio_oe_q, mdio_oe_d;
  logic          rd_req_q, rd_req_d;
  logic          wr_en_q, wr_en_d;
  logic          frame_err_q, frame_err_d;
  logic          mdc_rise, b;

  // Both inputs see the same two-flop latency so data stays aligned to its edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_s1_q  <= 1'b0;
      mdc_s2_q  <= 1'b0;
      mdc_s3_q  <= 1'b0;
      mdio_s1_q <= 1'b0;
      mdio_s2_q <= 1'b0;
    end else begin
      mdc_s1_q  <= mdc;
      mdc_s2_q  <= mdc_s1_q;
      mdc_s3_q  <= mdc_s2_q;
      mdio_s1_q <= mdio_i;
      mdio_s2_q <= mdio_s1_q;
    end
  end

  assign mdc_rise = mdc_s2_q & ~mdc_s3_q;
  assign b        = mdio_s2_q;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    pre_cnt_d     = pre_cnt_q;
    is_rd_d       = is_rd_q;
    drain_d       = drain_q;
    fld_d         = fld_q;
    reg_addr_d    = reg_addr_q;
    data_sh_d     = data_sh_q;
    reg_wr_data_d = reg_wr_data_q;
    mdio_o_d      = mdio_o_q;
    mdio_oe_d     = mdio_oe_q;
    rd_req_d      = 1'b0;
    wr_en_d       = 1'b0;
    frame_err_d   = 1'b0;
    if (mdc_rise) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
      unique case (state_q)
        S_IDLE: begin
          bit_cnt_d = 4'd0;
          if (b) begin
            if (pre_cnt_q != PW'(PRE_LEN)) pre_cnt_d = pre_cnt_q + 1'b1;
          end else begin
            pre_cnt_d = '0;
            if (pre_cnt_q == PW'(PRE_LEN)) state_d = S_ST;
          end
        end
        S_ST: begin
          bit_cnt_d = 4'd0;
          if (b) state_d = S_OP;
          else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_OP: begin
          fld_d = {fld_q[2:0], b};
          if (bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd0;
            unique case ({fld_q[0], b})
              2'b10: begin is_rd_d = 1'b1; state_d = S_PHYAD; end
              2'b01: begin is_rd_d = 1'b0; state_d = S_PHYAD; end
              default: begin frame_err_d = 1'b1; state_d = S_IDLE; end
            endcase
          end
        end
        S_PHYAD: begin
          fld_d = {fld_q[2:0], b};
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = 4'd0;
            // Another PHY's frame: drop out quietly, it is not an error.
            state_d   = ({fld_q, b} == PHY_ADDR) ? S_REGAD : S_IDLE;
          end
        end
        S_REGAD: begin
          reg_addr_d = {reg_addr_q[3:0], b};
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = 4'd0;
            rd_req_d  = is_rd_q;
            state_d   = S_TA;
          end
        end
        S_TA: begin
          fld_d = {fld_q[2:0], b};
          if (bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd0;
            if (is_rd_q) begin
              mdio_oe_d = 1'b1;
              mdio_o_d  = 1'b0;
              data_sh_d = reg_rd_data;
              state_d   = S_RDATA;
            end else if ({fld_q[0], b} == 2'b10) begin
              state_d = S_WDATA;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_IDLE;
            end
          end
        end
        S_RDATA: begin
          // One extra rise after bit 0 keeps the last bit on the pad a full period.
          if (drain_q) begin
            drain_d   = 1'b0;
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b0;
            state_d   = S_IDLE;
          end else begin
            mdio_o_d  = data_sh_q[15];
            data_sh_d = {data_sh_q[14:0], 1'b0};
            if (bit_cnt_q == 4'd15) drain_d = 1'b1;
          end
        end
        S_WDATA: begin
          data_sh_d = {data_sh_q[14:0], b};
          if (bit_cnt_q == 4'd15) begin
            reg_wr_data_d = {data_sh_q[14:0], b};
            wr_en_d       = 1'b1;
            state_d       = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      pre_cnt_q     <= '0;
      is_rd_q       <= 1'b0;
      drain_q       <= 1'b0;
      fld_q         <= '0;
      reg_addr_q    <= '0;
      data_sh_q     <= '0;
      reg_wr_data_q <= '0;
      mdio_o_q      <= 1'b0;
      mdio_oe_q     <= 1'b0;
      rd_req_q      <= 1'b0;
      wr_en_q       <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      pre_cnt_q     <= pre_cnt_d;
      is_rd_q       <= is_rd_d;
      drain_q       <= drain_d;
      fld_q         <= fld_d;
      reg_addr_q    <= reg_addr_d;
      data_sh_q     <= data_sh_d;
      reg_wr_data_q <= reg_wr_data_d;
      mdio_o_q      <= mdio_o_d;
      mdio_oe_q     <= mdio_oe_d;
      rd_req_q      <= rd_req_d;
      wr_en_q       <= wr_en_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign mdio_o      = mdio_o_q;
  assign mdio_oe     = mdio_oe_q;
  assign reg_addr    = reg_addr_q;
  assign reg_rd_req  = rd_req_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_data = reg_wr_data_q;
  assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_mdio_responder.sv
// Directed frame-level bench for mdio_responder: a station-manager model
// bit-bangs MDC/MDIO and a monitor tallies strobes on the clk side.
module tb_mdio_responder;
  logic        clk = 1'b0, rst_n = 1'b0, mdc = 1'b0, mdio_i = 1'b1;
  logic        mdio_o, mdio_oe, reg_rd_req, reg_wr_en, frame_err;
  logic [4:0]  reg_addr;
  logic [15:0] reg_rd_data = 16'h0000, reg_wr_data;

  mdio_responder #(.PHY_ADDR(5'd1), .PRE_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o),
    .mdio_oe(mdio_oe), .reg_addr(reg_addr), .reg_rd_req(reg_rd_req),
    .reg_rd_data(reg_rd_data), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  int errors = 0, checks = 0;
  int half = 4;  // MDC half period in clk cycles

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cumulative event counters; tests compare deltas around each frame.
  int rd_n = 0, wr_n = 0, err_n = 0, oe_n = 0;
  logic [4:0]  rd_addr = '0, wr_addr = '0;
  logic [15:0] wr_data = '0;
  always @(negedge clk) begin
    if (reg_rd_req) begin rd_n++; rd_addr = reg_addr; end
    if (reg_wr_en) begin wr_n++; wr_addr = reg_addr; wr_data = reg_wr_data; end
    if (frame_err) err_n++;
    if (mdio_oe) oe_n++;
  end

  // One MDC period: drive on the falling half, observe the PHY late in the high half.
  task automatic slot(input logic bv, output logic oe, output logic o);
    mdc = 1'b0;
    mdio_i = bv;
    repeat (half) @(negedge clk);
    mdc = 1'b1;
    repeat (half) @(negedge clk);
    oe = mdio_oe;
    o  = mdio_o;
  endtask

  // tinfo = {ta1_oe, ta2_oe, ta2_o, oe_after_data}; rst_at = read data bit at which reset is pulsed.
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] wd,
                       input int rst_at, output logic [15:0] rdv, output logic [3:0] tinfo);
    logic oe, o;
    rdv = '0;
    tinfo = '0;
    slot(1'b0, oe, o);
    repeat (pre) slot(1'b1, oe, o);
    slot(1'b0, oe, o);
    slot(1'b1, oe, o);
    for (int i = 1; i >= 0; i--) slot(op[i], oe, o);
    for (int i = 4; i >= 0; i--) slot(phy[i], oe, o);
    for (int i = 4; i >= 0; i--) slot(ra[i], oe, o);
    if (op == 2'b10) begin
      slot(1'b1, oe, o); tinfo[3] = oe;
      slot(1'b1, oe, o); tinfo[2] = oe; tinfo[1] = o;
      for (int i = 15; i >= 0; i--) begin
        slot(1'b1, oe, o);
        rdv[i] = oe ? o : 1'bx;
        if (i == rst_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_mid_oe", {31'd0, mdio_oe}, 32'd0);
          chk("rst_mid_o", {31'd0, mdio_o}, 32'd0);
          @(negedge clk);
          rst_n = 1'b1;
        end
      end
      slot(1'b1, oe, o); tinfo[0] = oe;
    end else begin
      for (int i = 1; i >= 0; i--) slot(ta[i], oe, o);
      for (int i = 15; i >= 0; i--) slot(wd[i], oe, o);
      slot(1'b1, oe, o);
    end
  endtask

  int r0, w0, e0, o0;
  logic [15:0] rdv;
  logic [3:0]  ti;

  task automatic snap();
    r0 = rd_n; w0 = wr_n; e0 = err_n; o0 = oe_n;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_oe", {31'd0, mdio_oe}, 32'd0);
    chk("rst_o", {31'd0, mdio_o}, 32'd0);
    chk("rst_strobes", {29'd0, reg_rd_req, reg_wr_en, frame_err}, 32'd0);
    chk("rst_addr", {27'd0, reg_addr}, 32'd0);
    chk("rst_wdata", {16'd0, reg_wr_data}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic read
    reg_rd_data = 16'h796D; snap();
    frame(32, 2'b10, 5'd1, 5'd1, 2'b10, 16'h0, -1, rdv, ti);
    chk("rd_req_cnt", rd_n - r0, 1);
    chk("rd_addr", {27'd0, rd_addr}, 32'd1);
    chk("rd_ta", {28'd0, ti}, 32'h4);
    chk("rd_data", {16'd0, rdv}, 32'h796D);
    chk("rd_no_err", err_n - e0, 0);

    // Basic write
    snap();
    frame(32, 2'b01, 5'd1, 5'h1F, 2'b10, 16'hA5C3, -1, rdv, ti);
    chk("wr_cnt", wr_n - w0, 1);
    chk("wr_data", {16'd0, wr_data}, 32'hA5C3);
    chk("wr_addr", {27'd0, wr_addr}, 32'h1F);
    chk("wr_oe", oe_n - o0, 0);
    chk("wr_no_rd", rd_n - r0, 0);

    // Address miss, then a hit
    snap();
    frame(32, 2'b10, 5'd2, 5'd1, 2'b10, 16'h0, -1, rdv, ti);
    chk("miss_rd", rd_n - r0, 0);
    chk("miss_err", err_n - e0, 0);
    chk("miss_oe", oe_n - o0, 0);
    reg_rd_data = 16'h1234; snap();
    frame(32, 2'b10, 5'd1, 5'd3, 2'b10, 16'h0, -1, rdv, ti);
    chk("hit_rd", rd_n - r0, 1);
    chk("hit_addr", {27'd0, rd_addr}, 32'd3);
    chk("hit_data", {16'd0, rdv}, 32'h1234);

    // Short preamble is ignored
    snap();
    frame(31, 2'b10, 5'd1, 5'd1, 2'b10, 16'h0, -1, rdv, ti);
    chk("pre31_rd", rd_n - r0, 0);
    chk("pre31_err", err_n - e0, 0);
    chk("pre31_oe", oe_n - o0, 0);

    // Bad opcode
    snap();
    frame(32, 2'b11, 5'd1, 5'd1, 2'b10, 16'h0, -1, rdv, ti);
    chk("op11_err", err_n - e0, 1);
    chk("op11_strobe", (rd_n - r0) + (wr_n - w0), 0);

    // Bad write turnaround
    snap();
    frame(32, 2'b01, 5'd1, 5'd4, 2'b11, 16'hFFFF, -1, rdv, ti);
    chk("ta11_err", err_n - e0, 1);
    chk("ta11_wr", wr_n - w0, 0);

    // Reset during read data, then recovery
    reg_rd_data = 16'hC3A5; snap();
    frame(32, 2'b10, 5'd1, 5'd7, 2'b10, 16'h0, 8, rdv, ti);
    chk("rst_partial_rd", rd_n - r0, 1);
    chk("rst_partial_err", err_n - e0, 0);
    snap();
    frame(32, 2'b10, 5'd1, 5'd7, 2'b10, 16'h0, -1, rdv, ti);
    chk("rst_rec_rd", rd_n - r0, 1);
    chk("rst_rec_data", {16'd0, rdv}, 32'hC3A5);
    chk("rst_rec_ta", {28'd0, ti}, 32'h4);

    // Back-to-back read/write at 500 kHz MDC (clk 50 MHz), then at clk/8
    for (int k = 0; k < 2; k++) begin
      half = (k == 0) ? 50 : 4;
      reg_rd_data = (k == 0) ? 16'h0F0F : 16'hBEEF; snap();
      frame(32, 2'b10, 5'd1, 5'd2, 2'b10, 16'h0, -1, rdv, ti);
      frame(32, 2'b01, 5'd1, 5'd4, 2'b10, 16'h5A5A ^ 16'(k), -1, rdv, ti);
      chk("b2b_rd_cnt", rd_n - r0, 1);
      chk("b2b_wr_cnt", wr_n - w0, 1);
      chk("b2b_wr_data", {16'd0, wr_data}, {16'd0, 16'h5A5A ^ 16'(k)});
      chk("b2b_wr_addr", {27'd0, wr_addr}, 32'd4);
      chk("b2b_err", err_n - e0, 0);
    end
    half = 4;
    frame(32, 2'b10, 5'd1, 5'd9, 2'b10, 16'h0, -1, rdv, ti);
    chk("b2b_final_rd", {16'd0, rdv}, 32'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
